// File: rtl/deadcode_pkg.sv
// Shared definitions for the deadcode pack pipeline: packer state encoding
// and the lane-counter width helper.
package deadcode_pkg;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   // Smallest r with 2**r >= n, never less than 1 so a counter always has a bit.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) begin
         r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/deadcode_delay_stage.sv
// One stage of the valid-tagged delay line: an enabled register of {valid, data}.
module deadcode_delay_stage
   import deadcode_pkg::*;
#(
   parameter int W = 9
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;

   // hold the stage contents unless the pipeline advances
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_q <= '0;
      end else if (en_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/deadcode_pack_pipe.sv
// Delays IN_WIDTH-bit words through a DEPTH-stage valid-tagged line and packs
// them, lane 0 in the LSBs, into WIDTH-bit words on a ready/valid output.
// Optional build macro DEADCODE_PACK_DEBUG_EN adds a last-input register, a
// group counter and a simulation trace; ports and behaviour are unchanged.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_FILL | no packed word pending; out_valid low, lanes being filled
// ST_HOLD | packed word on out; held until out_ready, may reload same cycle
module deadcode_pack_pipe
   import deadcode_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int IN_WIDTH = 8,
   parameter int DEPTH    = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_WIDTH-1:0] in,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out
);

   localparam int LANES  = WIDTH / IN_WIDTH;
   localparam int LANE_W = clog2(LANES);

   state_t              state_q, state_d;
   logic [LANE_W-1:0]   lane_q, lane_d;
   logic [WIDTH-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0]    out_q, out_d;
   logic [WIDTH-1:0]    merged;
   logic                adv;
   logic                word_vld;
   logic [IN_WIDTH-1:0] word;
   logic                consume;
   logic                complete;
   logic                flush_emit;
   logic                emit;
   int                  lane_base;

   logic [IN_WIDTH:0]   stg [DEPTH];

   // The whole pipe freezes only while a packed word waits for its consumer.
   assign out_valid = (state_q == ST_HOLD);
   assign adv       = !(out_valid && !out_ready);
   assign in_ready  = adv;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [IN_WIDTH:0] d;
      if (k == 0) begin : g_head
         assign d = {in_valid && in_ready, in};
      end else begin : g_tail
         assign d = stg[k-1];
      end
      deadcode_delay_stage #(
         .W(IN_WIDTH + 1)
      ) u_stage (
         .clock (clock),
         .reset (reset),
         .en_i  (adv),
         .d_i   (d),
         .q_o   (stg[k])
      );
   end

   assign word_vld  = stg[DEPTH-1][IN_WIDTH];
   assign word      = stg[DEPTH-1][IN_WIDTH-1:0];
   assign lane_base = int'(lane_q) * IN_WIDTH;

   assign consume    = adv && word_vld;
   assign complete   = consume && (lane_q == LANE_W'(LANES - 1));
   // A flush with nothing gathered and nothing arriving has nothing to emit.
   assign flush_emit = adv && flush && ((lane_q != '0) || word_vld);
   assign emit       = complete || flush_emit;

   // accumulator with the arriving word dropped into the current lane
   always_comb begin
      merged = acc_q;
      if (word_vld) begin
         merged[lane_base +: IN_WIDTH] = word;
      end
   end

   // next-state: handshake releases HOLD, an emission (re)loads it
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      acc_d   = acc_q;
      out_d   = out_q;
      case (state_q)
         ST_FILL: state_d = ST_FILL;
         ST_HOLD: if (out_ready) state_d = ST_FILL;
      endcase
      if (emit) begin
         out_d   = merged;
         state_d = ST_HOLD;
         lane_d  = '0;
         acc_d   = '0;
      end else if (consume) begin
         acc_d  = merged;
         lane_d = lane_q + LANE_W'(1);
      end
   end

   // packer state, lane counter, accumulator and output register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_FILL;
         lane_q  <= '0;
         acc_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         lane_q  <= lane_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
      end
   end

   assign out = out_q;

`ifdef DEADCODE_PACK_DEBUG_EN
   logic [IN_WIDTH-1:0] dbg_last_in_q;
   logic [15:0]         dbg_groups_q;

   // remember the last accepted word and count words handed downstream
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dbg_last_in_q <= '0;
         dbg_groups_q  <= '0;
      end else begin
         if (in_valid && in_ready) begin
            dbg_last_in_q <= in;
         end
         if (out_valid && out_ready) begin
            dbg_groups_q <= dbg_groups_q + 16'd1;
         end
      end
   end

`ifndef SYNTHESIS
   // trace every packed word at its handshake
   always @(posedge clock) begin
      if (!reset && out_valid && out_ready) begin
         $display("pack %0d = %h", dbg_groups_q, out);
      end
   end
`endif
`else
   // no debug state in this build
`endif

endmodule

// File: tb/tb_deadcode_pack_pipe.sv
// Bench for deadcode_pack_pipe: two instances (32/8/2 and 24/8/4) share one
// stimulus stream and are compared every cycle against a word-level model.
module tb_deadcode_pack_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       in_valid;
   logic [7:0] in_data;
   logic       flush;
   logic       out_ready;

   logic        in_ready0, out_valid0;
   logic [31:0] out0;
   logic        in_ready1, out_valid1;
   logic [23:0] out1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   deadcode_pack_pipe #(.WIDTH(32), .IN_WIDTH(8), .DEPTH(2)) u_dut0 (
      .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready0),
      .in(in_data), .flush(flush), .out_valid(out_valid0),
      .out_ready(out_ready), .out(out0));

   deadcode_pack_pipe #(.WIDTH(24), .IN_WIDTH(8), .DEPTH(4)) u_dut1 (
      .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready1),
      .in(in_data), .flush(flush), .out_valid(out_valid1),
      .out_ready(out_ready), .out(out1));

   // ---------------- word-level model ----------------
   // A word presented at advance number s reaches the packer at advance s+DEPTH.
   localparam int HN = 4096;
   int          lanes_m [2] = '{4, 3};
   int          depth_m [2] = '{2, 4};
   logic [8:0]  hist_m  [2][HN];
   logic [7:0]  grp_m   [2][4];
   int          grp_n   [2];
   int          step_m  [2];
   logic        ov_m    [2];
   logic [31:0] out_m   [2];

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         grp_n[i]  = 0;
         step_m[i] = 0;
         ov_m[i]   = 1'b0;
         out_m[i]  = '0;
      end
   endtask

   task automatic model_step(input int i);
      logic [8:0] arr;
      int s;
      if (ov_m[i] && !out_ready) return;
      s = step_m[i];
      if (s >= HN) begin
         $display("FAIL model_range: step %0d required below %0d", s, HN);
         errors++;
         $fatal(1, "model history exhausted");
      end
      arr = (s >= depth_m[i]) ? hist_m[i][s - depth_m[i]] : 9'd0;
      if (arr[8]) begin
         grp_m[i][grp_n[i]] = arr[7:0];
         grp_n[i]++;
      end
      ov_m[i] = 1'b0;
      if (grp_n[i] == lanes_m[i] || (flush && grp_n[i] > 0)) begin
         out_m[i] = '0;
         for (int k = 0; k < grp_n[i]; k++) out_m[i][k*8 +: 8] = grp_m[i][k];
         ov_m[i]  = 1'b1;
         grp_n[i] = 0;
      end
      hist_m[i][s] = {in_valid, in_data};
      step_m[i] = s + 1;
   endtask

   always @(posedge rst) model_clear();

   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) model_step(i);
      end
   end

   // ---------------- comparison ----------------
   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   logic [31:0] cap0[$], cap1[$];
   int          capc0[$], capc1[$];

   always @(negedge clk) begin
      cmp("in_ready0",  {31'd0, in_ready0},  {31'd0, !(ov_m[0] && !out_ready)});
      cmp("out_valid0", {31'd0, out_valid0}, {31'd0, ov_m[0]});
      cmp("out0",       out0,                out_m[0]);
      cmp("in_ready1",  {31'd0, in_ready1},  {31'd0, !(ov_m[1] && !out_ready)});
      cmp("out_valid1", {31'd0, out_valid1}, {31'd0, ov_m[1]});
      cmp("out1",       {8'h00, out1},       out_m[1]);
      if (out_valid0 && out_ready) begin
         cap0.push_back(out0);
         capc0.push_back(cyc);
      end
      if (out_valid1 && out_ready) begin
         cap1.push_back({8'h00, out1});
         capc1.push_back(cyc);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      in_valid = 1'b0;
      flush    = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] d, output int t);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      t = cyc;
      in_valid = 1'b1;
      in_data  = d;
      while (!done) begin
         t = cyc;
         @(negedge clk);
         done = in_ready0;
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h not accepted within %0d cycles", d, n);
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic reset_pulse();
      #2 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      cap0.delete(); cap1.delete(); capc0.delete(); capc1.delete();
   endtask

   function automatic logic [31:0] qv(input logic [31:0] q[$], input int idx);
      return (idx < q.size()) ? q[idx] : 32'hDEAD_BEEF;
   endfunction

   function automatic int qc(input int q[$], input int idx);
      return (idx < q.size()) ? q[idx] : -1;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t, t3, t4, t6;
      in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      cmp("rst_out0",    out0, 32'h0);
      cmp("rst_ovalid0", {31'd0, out_valid0}, 32'd0);
      cmp("rst_iready0", {31'd0, in_ready0},  32'd1);
      rst = 1'b0;

      // 24/8/4 instance: two back-to-back groups, latency t+5
      send(8'h01, t); send(8'h02, t); send(8'h03, t3);
      send(8'h04, t4); send(8'h05, t); send(8'h06, t6);
      idle(10);
      cmp("t6_count",  cap1.size(), 2);
      cmp("t6_word0",  qv(cap1, 0), 32'h00030201);
      cmp("t6_word1",  qv(cap1, 1), 32'h00060504);
      cmp("t6_cycle0", qc(capc1, 0), t3 + 5);
      cmp("t6_cycle1", qc(capc1, 1), t6 + 5);
      cmp("t6_w0_32",  qv(cap0, 0), 32'h04030201);
      cmp("t6_c0_32",  qc(capc0, 0), t4 + 3);

      // single group, latency t+DEPTH+1, one cycle of out_valid
      reset_pulse();
      send(8'h11, t); send(8'h22, t); send(8'h33, t); send(8'h44, t);
      idle(6);
      cmp("t1_count", cap0.size(), 1);
      cmp("t1_word",  qv(cap0, 0), 32'h44332211);
      cmp("t1_cycle", qc(capc0, 0), t + 3);

      // backpressure: nothing lost or duplicated
      reset_pulse();
      out_ready = 1'b0;
      fork
         begin
            repeat (12) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            for (int w = 1; w <= 8; w++) send(8'(w), t);
         end
      join
      idle(8);
      cmp("t2_count", cap0.size(), 2);
      cmp("t2_word0", qv(cap0, 0), 32'h04030201);
      cmp("t2_word1", qv(cap0, 1), 32'h08070605);

      // flush with partial group, then idle flush is a no-op
      reset_pulse();
      send(8'hAA, t); send(8'hBB, t);
      idle(3);
      pulse_flush();
      idle(4);
      pulse_flush();
      idle(4);
      cmp("t3_count", cap0.size(), 1);
      cmp("t3_word",  qv(cap0, 0), 32'h0000BBAA);

      // flush coinciding with the third word reaching the packer
      reset_pulse();
      send(8'hAA, t); send(8'hBB, t); send(8'hCC, t);
      idle(1);
      pulse_flush();
      idle(4);
      cmp("t4_count", cap0.size(), 1);
      cmp("t4_word",  qv(cap0, 0), 32'h00CCBBAA);

      // asynchronous reset mid-group clears output immediately
      reset_pulse();
      out_ready = 1'b0;
      for (int w = 1; w <= 6; w++) send(8'(w), t);
      idle(2);
      cmp("t5_pre_out",   out0, 32'h04030201);
      cmp("t5_pre_valid", {31'd0, out_valid0}, 32'd1);
      #2 rst = 1'b1;
      #1;
      cmp("t5_rst_out",   out0, 32'h0);
      cmp("t5_rst_valid", {31'd0, out_valid0}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      cap0.delete(); cap1.delete(); capc0.delete(); capc1.delete();
      out_ready = 1'b1;
      send(8'h11, t); send(8'h12, t); send(8'h13, t); send(8'h14, t);
      idle(6);
      cmp("t5_count", cap0.size(), 1);
      cmp("t5_word",  qv(cap0, 0), 32'h14131211);

      // randomized traffic against the model
      for (int n = 0; n < 2500; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         flush     = ($urandom_range(0, 9) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      idle(6);
      pulse_flush();
      idle(8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
